// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue/result sequencer for the 4-bit ALU register
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_data,
  input  logic [1:0]                 cmd_op,
  input  logic                       flush,
  output logic [3:0]                 alu_data_in,
  output logic [1:0]                 alu_op,
  output logic                       alu_load,
  input  logic [3:0]                 alu_data_out,
  input  logic                       alu_zero,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [3:0]                 res_data,
  output logic                       res_zero,
  output logic [CNT_W-1:0]           zero_count,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_nxt;

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_after;
  logic [5:0]    head;
  logic [3:0]    last_data;
  logic [1:0]    last_op;
  logic          full, push, pop, hs;

  assign full      = (count == FULL_LVL);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;
  assign pop       = (state == ISSUE);
  assign head      = mem[rd_ptr];
  assign res_valid = (state == WAIT);
  assign hs        = res_valid && res_ready;

  // Occupancy seen by the WAIT exit decision: pop is never active in WAIT.
  assign count_after = flush ? '0 : count + {{AW{1'b0}}, push};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_data, cmd_op};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0 && !flush) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (hs) state_nxt = (count_after != '0) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand outputs show the FIFO head while issuing and hold it afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_data <= '0;
      last_op   <= '0;
    end else if (state == ISSUE) begin
      last_data <= head[5:2];
      last_op   <= head[1:0];
    end
  end

  assign alu_load    = (state == ISSUE);
  assign alu_data_in = alu_load ? head[5:2] : last_data;
  assign alu_op      = alu_load ? head[1:0] : last_op;

  assign res_data = res_valid ? alu_data_out : 4'h0;
  assign res_zero = res_valid && alu_zero;

  always_ff @(posedge clk) begin
    if (!reset) begin
      zero_count <= '0;
    end else if (hs && res_zero && zero_count != {CNT_W{1'b1}}) begin
      zero_count <= zero_count + 1'b1;
    end
  end

  assign fifo_level = count;
  assign busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_data = 4'h0;
  logic [1:0] cmd_op = 2'b00;
  logic       flush = 1'b0;
  logic       res_ready = 1'b0;

  logic       cmd_ready, alu_load, res_valid, res_zero, busy, alu_zero;
  logic [3:0] alu_data_in, alu_data_out, res_data;
  logic [1:0] alu_op;
  logic [7:0] zero_count;
  logic [2:0] fifo_level;
  logic [3:0] alu_reg = 4'h0;

  logic       s_cmd_ready, s_alu_load, s_res_valid, s_res_zero, s_busy, s_alu_zero;
  logic [3:0] s_alu_data_in, s_alu_data_out, s_res_data;
  logic [1:0] s_alu_op;
  logic [1:0] s_zero_count;
  logic [2:0] s_fifo_level;
  logic [3:0] s_alu_reg = 4'h0;

  int n_checks = 0;
  int n_fail = 0;
  int loads = 0;
  logic [3:0] exp_res [5] = '{4'hB, 4'hF, 4'h2, 4'hD, 4'h2};

  alu_cmd_sequencer #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_op(cmd_op), .flush(flush),
    .alu_data_in(alu_data_in), .alu_op(alu_op), .alu_load(alu_load),
    .alu_data_out(alu_data_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .zero_count(zero_count), .fifo_level(fifo_level), .busy(busy)
  );

  alu_cmd_sequencer #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_data(cmd_data), .cmd_op(cmd_op), .flush(flush),
    .alu_data_in(s_alu_data_in), .alu_op(s_alu_op), .alu_load(s_alu_load),
    .alu_data_out(s_alu_data_out), .alu_zero(s_alu_zero),
    .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data), .res_zero(s_res_zero),
    .zero_count(s_zero_count), .fifo_level(s_fifo_level), .busy(s_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [3:0] d, input logic [1:0] op);
    case (op)
      2'b00:   return d + 4'd1;
      2'b01:   return d - 4'd1;
      2'b10:   return d & 4'b1010;
      default: return d | 4'b0101;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_load) begin
      alu_reg <= alu_f(alu_data_in, alu_op);
      loads <= loads + 1;
    end
    if (s_alu_load) s_alu_reg <= alu_f(s_alu_data_in, s_alu_op);
  end

  assign alu_data_out   = alu_reg;
  assign alu_zero       = (alu_reg == 4'h0);
  assign s_alu_data_out = s_alu_reg;
  assign s_alu_zero     = (s_alu_reg == 4'h0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic [1:0] op);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_op    = op;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cmd_valid = 1'b1;
    cmd_data = 4'h5;
    step();
    step();
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++; if (alu_load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", alu_load); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_checks++; if (zero_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", zero_count); end
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy: got %b%b want 10", cmd_ready, busy); end
    n_checks++; if (alu_data_in !== 4'h0 || alu_op !== 2'b00) begin n_fail++; $display("FAIL reset_alu_in: got %h/%b want 0/00", alu_data_in, alu_op); end
    cmd_valid = 1'b0;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int l0;
    res_ready = 1'b0;
    l0 = loads;
    push(4'hF, 2'b00);
    n_checks++; if (fifo_level !== 3'd1 || alu_load !== 1'b0) begin n_fail++; $display("FAIL single_queued: got lvl %0d load %b want 1 0", fifo_level, alu_load); end
    step();
    n_checks++; if (alu_load !== 1'b1 || alu_data_in !== 4'hF || alu_op !== 2'b00) begin n_fail++; $display("FAIL single_issue: got %b %h %b want 1 f 00", alu_load, alu_data_in, alu_op); end
    step();
    n_checks++; if (res_valid !== 1'b1 || res_data !== 4'h0 || res_zero !== 1'b1) begin n_fail++; $display("FAIL single_result: got %b %h %b want 1 0 1", res_valid, res_data, res_zero); end
    n_checks++; if (alu_load !== 1'b0 || alu_data_in !== 4'hF || fifo_level !== 3'd0) begin n_fail++; $display("FAIL single_hold: got %b %h %0d want 0 f 0", alu_load, alu_data_in, fifo_level); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || zero_count !== 8'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: got %b %0d %b want 0 1 0", res_valid, zero_count, busy); end
    n_checks++; if (loads - l0 !== 1) begin n_fail++; $display("FAIL single_load_pulses: got %0d want 1", loads - l0); end
  endtask

  task automatic test_fill();
    res_ready = 1'b0;
    push(4'hA, 2'b00);
    push(4'h0, 2'b01);
    push(4'h7, 2'b10);
    push(4'h8, 2'b11);
    n_checks++; if (fifo_level !== 3'd3 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fill_level3: got %0d %b want 3 1", fifo_level, cmd_ready); end
    push(4'h3, 2'b01);
    n_checks++; if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %0d %b want 4 0", fifo_level, cmd_ready); end
    cmd_valid = 1'b1;
    cmd_data = 4'h9;
    step();
    cmd_valid = 1'b0;
    n_checks++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fill_no_push_full: got %0d want 4", fifo_level); end
  endtask

  task automatic test_backpressure();
    int l0;
    l0 = loads;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (res_valid !== 1'b1 || alu_load !== 1'b0 || res_data !== 4'hB) begin n_fail++; $display("FAIL bp_hold%0d: got %b %b %h want 1 0 b", i, res_valid, alu_load, res_data); end
    end
    n_checks++; if (loads !== l0) begin n_fail++; $display("FAIL bp_loads: got %0d want %0d", loads, l0); end
  endtask

  task automatic test_back_to_back();
    int n;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!res_valid && n < 10) begin
        step();
        n++;
      end
      n_checks++; if (res_valid !== 1'b1 || res_data !== exp_res[i]) begin n_fail++; $display("FAIL drain_res%0d: got %b %h want 1 %h", i, res_valid, res_data, exp_res[i]); end
      step();
    end
    step();
    res_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || fifo_level !== 3'd0 || zero_count !== 8'd1) begin n_fail++; $display("FAIL drain_end: got %b %0d %0d want 0 0 1", busy, fifo_level, zero_count); end
  endtask

  task automatic test_flush();
    int l0;
    res_ready = 1'b0;
    push(4'hF, 2'b00);
    push(4'h1, 2'b00);
    push(4'h2, 2'b00);
    push(4'h3, 2'b00);
    n_checks++; if (fifo_level !== 3'd3 || res_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0d %b want 3 1", fifo_level, res_valid); end
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_data = 4'h5;
    step();
    flush = 1'b0;
    cmd_valid = 1'b0;
    l0 = loads;
    n_checks++; if (fifo_level !== 3'd0 || res_valid !== 1'b1 || res_data !== 4'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL flush_pending: got %0d %b %h %b want 0 1 0 1", fifo_level, res_valid, res_data, busy); end
    res_ready = 1'b1;
    step();
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || zero_count !== 8'd2) begin n_fail++; $display("FAIL flush_done: got %b %b %0d want 0 0 2", res_valid, busy, zero_count); end
    step();
    step();
    n_checks++; if (loads !== l0) begin n_fail++; $display("FAIL flush_no_issue: got %0d want %0d", loads, l0); end
    push(4'h6, 2'b00);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (fifo_level !== 3'd0 || alu_load !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %0d %b %b want 0 0 0", fifo_level, alu_load, busy); end
    step();
    n_checks++; if (loads !== l0 || alu_load !== 1'b0) begin n_fail++; $display("FAIL flush_idle_noload: got %0d %b want %0d 0", loads, alu_load, l0); end
    res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    n_checks++; if (s_zero_count !== 2'd2) begin n_fail++; $display("FAIL sat_pre: got %0d want 2", s_zero_count); end
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(4'hF, 2'b00);
    n = 0;
    while ((busy || s_busy) && n < 100) begin
      step();
      n++;
    end
    n_checks++; if (n >= 100) begin n_fail++; $display("FAIL sat_timeout: got %0d cycles want <100", n); end
    n_checks++; if (s_zero_count !== 2'd3) begin n_fail++; $display("FAIL sat_count: got %0d want 3", s_zero_count); end
    n_checks++; if (zero_count !== 8'd7) begin n_fail++; $display("FAIL sat_main_count: got %0d want 7", zero_count); end
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
